ppi_handshake_core: RTL and testbench

PPI_HANDSHAKE_CORE -- requirements
Module: ppi_handshake_core

---
 rtl/ppi_pkg.sv | 38 +++
 rtl/ppi_port_channel.sv | 146 ++++++++++++++
 rtl/ppi_handshake_core.sv | 125 ++++++++++++
 tb/tb_ppi_handshake_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared encodings for the PPI handshake core: port modes, channel states,
// control-word bit positions and register address offsets.
package ppi_pkg;

    // Port operating modes; bit 0 set means the port drives its pins.
    typedef enum logic [1:0] {
        MODE_BASIC_IN    = 2'b00,
        MODE_BASIC_OUT   = 2'b01,
        MODE_STROBED_IN  = 2'b10,
        MODE_STROBED_OUT = 2'b11
    } ppi_mode_e;

    // Handshake progress of one port.
    typedef enum logic [2:0] {
        ST_IDLE,       // no buffered data
        ST_IN_FULL,    // strobed input captured, waiting for a read
        ST_OUT_FULL,   // strobed output written, waiting for nACK low
        ST_OUT_ACKED,  // nACK seen low, waiting for it to return high
        ST_OUT_DONE    // peripheral finished, INTR follows INTE
    } chan_state_e;

    // Control-word layout.
    localparam int CW_MODESET_BIT = 7;
    localparam int CW_PORT_MSB    = 5;
    localparam int CW_PORT_LSB    = 4;
    localparam int CW_MODE_MSB    = 1;
    localparam int CW_MODE_LSB    = 0;
    localparam int CW_INTE_BIT    = 0;

    // Control and status registers sit just above the port data registers.
    localparam int CTRL_OFS = 0;
    localparam int STAT_OFS = 1;

    function automatic logic mode_drives(input ppi_mode_e m);
        return (m == MODE_BASIC_OUT) || (m == MODE_STROBED_OUT);
    endfunction

endpackage

// File: rtl/ppi_port_channel.sv
// One PPI port: mode register, output/input latches, strobe/ack
// synchronisers, handshake state machine, INTE and INTR.
module ppi_port_channel
    import ppi_pkg::*;
#(
    parameter int PORT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_set,
    input  ppi_mode_e         mode_val,
    input  logic              inte_wr,
    input  logic              inte_val,
    input  logic              data_wr,
    input  logic [PORT_W-1:0] data_val,
    input  logic              rd_done,
    input  logic              nstb,
    input  logic              nack,
    input  logic [PORT_W-1:0] pin,
    output ppi_mode_e         mode,
    output logic [PORT_W-1:0] out_latch,
    output logic [PORT_W-1:0] in_latch,
    output logic              ibf,
    output logic              nobf,
    output logic              intr,
    output logic              pen
);

    ppi_mode_e         mode_reg, mode_next;
    chan_state_e       state_reg, state_next;
    logic [PORT_W-1:0] out_latch_reg, out_latch_next;
    logic [PORT_W-1:0] in_latch_reg, in_latch_next;
    logic              inte_reg, inte_next;
    logic              intr_reg, intr_next;

    logic stb_s1_reg, stb_s2_reg, stb_hist_reg, stb_armed_reg;
    logic ack_s1_reg, ack_s2_reg, ack_hist_reg;
    logic stb_fall, ack_fall, ack_rise;

    // Two-flop synchronisers plus one history flop for edge detection.
    // stb_armed_reg only lets a strobe count if the port was already in
    // strobed-input mode, so a strobe straddling reset release is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_s1_reg    <= 1'b1;
            stb_s2_reg    <= 1'b1;
            stb_hist_reg  <= 1'b1;
            stb_armed_reg <= 1'b0;
            ack_s1_reg    <= 1'b1;
            ack_s2_reg    <= 1'b1;
            ack_hist_reg  <= 1'b1;
        end else begin
            stb_s1_reg    <= nstb;
            stb_s2_reg    <= stb_s1_reg;
            stb_hist_reg  <= stb_s2_reg;
            stb_armed_reg <= (mode_reg == MODE_STROBED_IN);
            ack_s1_reg    <= nack;
            ack_s2_reg    <= ack_s1_reg;
            ack_hist_reg  <= ack_s2_reg;
        end
    end

    assign stb_fall = stb_armed_reg & stb_hist_reg & ~stb_s2_reg;
    assign ack_fall = ack_hist_reg & ~ack_s2_reg;
    assign ack_rise = ~ack_hist_reg & ack_s2_reg;

    // State, mode, latches and interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg      <= MODE_BASIC_IN;
            state_reg     <= ST_IDLE;
            out_latch_reg <= '0;
            in_latch_reg  <= '0;
            inte_reg      <= 1'b0;
            intr_reg      <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            state_reg     <= state_next;
            out_latch_reg <= out_latch_next;
            in_latch_reg  <= in_latch_next;
            inte_reg      <= inte_next;
            intr_reg      <= intr_next;
        end
    end

    // Handshake next-state logic; INTR is recomputed from the next state
    // and the current INTE, so an INTE change shows on INTR one cycle later.
    always_comb begin
        mode_next      = mode_reg;
        state_next     = state_reg;
        out_latch_next = out_latch_reg;
        in_latch_next  = in_latch_reg;
        inte_next      = inte_reg;
        intr_next      = 1'b0;
        if (mode_set) begin
            mode_next      = mode_val;
            state_next     = ST_IDLE;
            out_latch_next = '0;
            inte_next      = 1'b0;
        end else begin
            if (inte_wr) begin
                inte_next = inte_val;
            end
            if (data_wr) begin
                out_latch_next = data_val;
            end
            case (mode_reg)
                MODE_STROBED_IN: begin
                    // A read completing on the same edge as a strobe frees
                    // the buffer first, so the strobe captures new data.
                    if (rd_done) begin
                        state_next = ST_IDLE;
                    end
                    if (stb_fall && (state_next == ST_IDLE)) begin
                        in_latch_next = pin;
                        state_next    = ST_IN_FULL;
                    end
                    intr_next = inte_reg & (state_next == ST_IN_FULL) & stb_s2_reg;
                end
                MODE_STROBED_OUT: begin
                    // A CPU write beats an ack falling on the same edge.
                    if (data_wr) begin
                        state_next = ST_OUT_FULL;
                    end else if ((state_reg == ST_OUT_FULL) && ack_fall) begin
                        state_next = ST_OUT_ACKED;
                    end else if ((state_reg == ST_OUT_ACKED) && ack_rise) begin
                        state_next = ST_OUT_DONE;
                    end
                    intr_next = inte_reg & (state_next == ST_OUT_DONE);
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign mode      = mode_reg;
    assign out_latch = out_latch_reg;
    assign in_latch  = in_latch_reg;
    assign ibf       = (state_reg == ST_IN_FULL);
    assign nobf      = (state_reg != ST_OUT_FULL);
    assign intr      = intr_reg;
    assign pen       = mode_drives(mode_reg);

endmodule

// File: rtl/ppi_handshake_core.sv
// Programmable parallel interface: CPU bus decode, NUM_PORTS handshake
// channels and the combinational read-back multiplexer.
module ppi_handshake_core
    import ppi_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int PORT_W    = 8,
    localparam int AW        = $clog2(NUM_PORTS + 2)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        nCS,
    input  logic                        nRD,
    input  logic                        nWR,
    input  logic [AW-1:0]               A,
    input  logic [7:0]                  Din,
    output logic [7:0]                  Dout,
    output logic                        DEn,
    input  logic [NUM_PORTS*PORT_W-1:0] Pin,
    output logic [NUM_PORTS*PORT_W-1:0] Pout,
    output logic [NUM_PORTS-1:0]        PEn,
    input  logic [NUM_PORTS-1:0]        nSTB,
    input  logic [NUM_PORTS-1:0]        nACK,
    output logic [NUM_PORTS-1:0]        IBF,
    output logic [NUM_PORTS-1:0]        nOBF,
    output logic [NUM_PORTS-1:0]        INTR
);

    localparam logic [AW-1:0] CTRL_ADDR = AW'(NUM_PORTS + CTRL_OFS);
    localparam logic [AW-1:0] STAT_ADDR = AW'(NUM_PORTS + STAT_OFS);

    logic          nwr_prev_reg, nrd_prev_reg;
    logic [AW-1:0] addr_reg;
    logic [7:0]    din_reg;
    logic          wr_commit, rd_commit, ctrl_wr;
    logic [1:0]    ctrl_port;

    ppi_mode_e         port_mode [NUM_PORTS];
    logic [PORT_W-1:0] out_latch [NUM_PORTS];
    logic [PORT_W-1:0] in_latch  [NUM_PORTS];

    // Bus sampling: a write or read completes on the rising edge of
    // nWR/nRD and uses the address and data from the cycle before.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nwr_prev_reg <= 1'b1;
            nrd_prev_reg <= 1'b1;
            addr_reg     <= '0;
            din_reg      <= '0;
        end else begin
            nwr_prev_reg <= nWR;
            nrd_prev_reg <= nRD;
            addr_reg     <= A;
            din_reg      <= Din;
        end
    end

    assign wr_commit = ~nwr_prev_reg & nWR & ~nCS;
    assign rd_commit = ~nrd_prev_reg & nRD & ~nCS;
    assign ctrl_wr   = wr_commit & (addr_reg == CTRL_ADDR);
    assign ctrl_port = din_reg[CW_PORT_MSB:CW_PORT_LSB];

    // Control words naming a port index with no channel match nothing here.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic sel_ctrl, mode_set, inte_wr, data_wr, rd_done;

        assign sel_ctrl = ctrl_wr & (ctrl_port == 2'(gi));
        assign mode_set = sel_ctrl & din_reg[CW_MODESET_BIT];
        assign inte_wr  = sel_ctrl & ~din_reg[CW_MODESET_BIT];
        assign data_wr  = wr_commit & (addr_reg == AW'(gi));
        assign rd_done  = rd_commit & (addr_reg == AW'(gi));

        ppi_port_channel #(
            .PORT_W(PORT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .mode_set  (mode_set),
            .mode_val  (ppi_mode_e'(din_reg[CW_MODE_MSB:CW_MODE_LSB])),
            .inte_wr   (inte_wr),
            .inte_val  (din_reg[CW_INTE_BIT]),
            .data_wr   (data_wr),
            .data_val  (din_reg[PORT_W-1:0]),
            .rd_done   (rd_done),
            .nstb      (nSTB[gi]),
            .nack      (nACK[gi]),
            .pin       (Pin[gi*PORT_W +: PORT_W]),
            .mode      (port_mode[gi]),
            .out_latch (out_latch[gi]),
            .in_latch  (in_latch[gi]),
            .ibf       (IBF[gi]),
            .nobf      (nOBF[gi]),
            .intr      (INTR[gi]),
            .pen       (PEn[gi])
        );

        assign Pout[gi*PORT_W +: PORT_W] = out_latch[gi];
    end

    assign DEn = ~nCS & ~nRD;

    // Read-back mux on the live address; unused addresses and bits read 0.
    always_comb begin
        Dout = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (A == AW'(k)) begin
                case (port_mode[k])
                    MODE_BASIC_IN:   Dout = 8'(Pin[k*PORT_W +: PORT_W]);
                    MODE_STROBED_IN: Dout = 8'(in_latch[k]);
                    default:         Dout = 8'(out_latch[k]);
                endcase
            end
        end
        if (A == CTRL_ADDR) begin
            Dout = {6'b0, port_mode[0]};
        end
        if (A == STAT_ADDR) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                Dout[2*k]   = IBF[k] | ~nOBF[k];
                Dout[2*k+1] = INTR[k];
            end
        end
    end

endmodule

// File: tb/tb_ppi_handshake_core.sv
// Directed bench: default 2x8 core plus a 4x4 core for the wide-address case.
module tb_ppi_handshake_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        nRD, nWR;
    logic [7:0]  Din;

    // default configuration: NUM_PORTS=2, PORT_W=8
    logic        nCS;
    logic [1:0]  A;
    logic [7:0]  Dout;
    logic        DEn;
    logic [15:0] Pin, Pout;
    logic [1:0]  PEn, nSTB, nACK, IBF, nOBF, INTR;

    // wide configuration: NUM_PORTS=4, PORT_W=4
    logic        nCS4;
    logic [2:0]  A4;
    logic [7:0]  Dout4;
    logic        DEn4;
    logic [15:0] Pin4, Pout4;
    logic [3:0]  PEn4, nSTB4, nACK4, IBF4, nOBF4, INTR4;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rd;
    logic        den;

    always #5 clk = ~clk;

    ppi_handshake_core dut (
        .clk(clk), .reset(reset), .nCS(nCS), .nRD(nRD), .nWR(nWR), .A(A),
        .Din(Din), .Dout(Dout), .DEn(DEn), .Pin(Pin), .Pout(Pout), .PEn(PEn),
        .nSTB(nSTB), .nACK(nACK), .IBF(IBF), .nOBF(nOBF), .INTR(INTR)
    );

    ppi_handshake_core #(.NUM_PORTS(4), .PORT_W(4)) dut4 (
        .clk(clk), .reset(reset), .nCS(nCS4), .nRD(nRD), .nWR(nWR), .A(A4),
        .Din(Din), .Dout(Dout4), .DEn(DEn4), .Pin(Pin4), .Pout(Pout4), .PEn(PEn4),
        .nSTB(nSTB4), .nACK(nACK4), .IBF(IBF4), .nOBF(nOBF4), .INTR(INTR4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input bit sel4, input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        A = addr[1:0]; A4 = addr; Din = data; nWR = 1'b0;
        if (sel4) nCS4 = 1'b0; else nCS = 1'b0;
        @(negedge clk);
        nWR = 1'b1;
        @(negedge clk);
        nCS = 1'b1; nCS4 = 1'b1;
        $display("write dut%0d A=%0d D=%h", sel4 ? 4 : 2, addr, data);
    endtask

    task automatic bus_read(input bit sel4, input logic [2:0] addr,
                            output logic [7:0] data, output logic en);
        @(negedge clk);
        A = addr[1:0]; A4 = addr; nRD = 1'b0;
        if (sel4) nCS4 = 1'b0; else nCS = 1'b0;
        @(negedge clk);
        data = sel4 ? Dout4 : Dout;
        en   = sel4 ? DEn4 : DEn;
        nRD  = 1'b1;
        @(negedge clk);
        nCS = 1'b1; nCS4 = 1'b1;
        $display("read  dut%0d A=%0d D=%h", sel4 ? 4 : 2, addr, data);
    endtask

    initial begin
        reset = 1'b1; nCS = 1'b1; nCS4 = 1'b1; nRD = 1'b1; nWR = 1'b1;
        A = '0; A4 = '0; Din = '0; Pin = '0; Pin4 = '0;
        nSTB = '1; nACK = '1; nSTB4 = '1; nACK4 = '1;
        wait_cycles(3);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_pen", 16'(PEn), 16'h0);
        check("rst_nobf", 16'(nOBF), 16'h3);
        check("rst_ibf", 16'(IBF), 16'h0);
        check("rst_intr", 16'(INTR), 16'h0);
        check("rst_pout", Pout, 16'h0);
        check("idle_den", 16'(DEn), 16'h0);
        bus_read(1'b0, 3'd3, rd, den);
        check("rst_status", 16'(rd), 16'h00);
        check("read_den", 16'(den), 16'h1);

        // port 0 strobed output with INTE
        bus_write(1'b0, 3'd2, 8'h83);
        check("m11_pen", 16'(PEn), 16'h1);
        check("m11_nobf", 16'(nOBF), 16'h3);
        bus_read(1'b0, 3'd2, rd, den);
        check("ctrl_read", 16'(rd), 16'h03);
        bus_write(1'b0, 3'd2, 8'h01);
        bus_write(1'b0, 3'd0, 8'hA5);
        check("out_pout", 16'(Pout[7:0]), 16'hA5);
        check("out_nobf", 16'(nOBF[0]), 16'h0);
        check("out_intr", 16'(INTR[0]), 16'h0);
        bus_read(1'b0, 3'd3, rd, den);
        check("out_status", 16'(rd), 16'h01);
        nACK[0] = 1'b0;
        wait_cycles(4);
        check("ack_fall_nobf", 16'(nOBF[0]), 16'h1);
        check("ack_low_intr", 16'(INTR[0]), 16'h0);
        nACK[0] = 1'b1;
        wait_cycles(4);
        check("ack_rise_intr", 16'(INTR[0]), 16'h1);
        bus_read(1'b0, 3'd3, rd, den);
        check("ack_status", 16'(rd), 16'h02);

        // port 1 strobed input with INTE, latency and ignored second strobe
        bus_write(1'b0, 3'd2, 8'h92);
        bus_write(1'b0, 3'd2, 8'h11);
        check("m10_pen", 16'(PEn), 16'h1);
        Pin[15:8] = 8'h3C;
        nSTB[1] = 1'b0;
        wait_cycles(2);
        check("stb_lat2_ibf", 16'(IBF[1]), 16'h0);
        wait_cycles(1);
        check("stb_lat3_ibf", 16'(IBF[1]), 16'h1);
        check("stb_low_intr", 16'(INTR[1]), 16'h0);
        nSTB[1] = 1'b1;
        wait_cycles(4);
        check("stb_intr", 16'(INTR[1]), 16'h1);
        bus_read(1'b0, 3'd3, rd, den);
        check("in_status", 16'(rd), 16'h0E);
        Pin[15:8] = 8'h77;
        nSTB[1] = 1'b0; wait_cycles(4);
        nSTB[1] = 1'b1; wait_cycles(4);
        check("stb_ignored_ibf", 16'(IBF[1]), 16'h1);
        bus_read(1'b0, 3'd1, rd, den);
        check("rd_first", 16'(rd), 16'h3C);
        check("rd_clr_ibf", 16'(IBF[1]), 16'h0);
        check("rd_clr_intr", 16'(INTR[1]), 16'h0);

        // read completion on the same edge as a strobe fall
        nSTB[1] = 1'b0; wait_cycles(4);
        nSTB[1] = 1'b1; wait_cycles(4);
        check("refill_ibf", 16'(IBF[1]), 16'h1);
        Pin[15:8] = 8'h5A;
        nSTB[1] = 1'b0;
        @(negedge clk);
        A = 2'd1; A4 = 3'd1; nCS = 1'b0; nRD = 1'b0;
        @(negedge clk);
        rd = Dout; nRD = 1'b1;
        @(negedge clk);
        nCS = 1'b1;
        $display("read  dut2 A=1 D=%h (coincident strobe)", rd);
        check("coinc_rd_old", 16'(rd), 16'h77);
        check("coinc_ibf", 16'(IBF[1]), 16'h1);
        nSTB[1] = 1'b1;
        wait_cycles(4);
        bus_read(1'b0, 3'd1, rd, den);
        check("coinc_rd_new", 16'(rd), 16'h5A);
        check("coinc_after_ibf", 16'(IBF[1]), 16'h0);

        // port write on the same edge as an ack fall: write wins
        bus_write(1'b0, 3'd0, 8'h11);
        check("wr2_nobf", 16'(nOBF[0]), 16'h0);
        check("wr2_intr", 16'(INTR[0]), 16'h0);
        nACK[0] = 1'b0;
        @(negedge clk);
        A = 2'd0; A4 = 3'd0; Din = 8'hC3; nWR = 1'b0; nCS = 1'b0;
        @(negedge clk);
        nWR = 1'b1;
        @(negedge clk);
        nCS = 1'b1;
        $display("write dut2 A=0 D=c3 (coincident ack)");
        check("coinc_wr_nobf", 16'(nOBF[0]), 16'h0);
        check("coinc_wr_pout", 16'(Pout[7:0]), 16'hC3);
        nACK[0] = 1'b1;
        wait_cycles(4);
        check("late_rise_intr", 16'(INTR[0]), 16'h0);
        check("late_rise_nobf", 16'(nOBF[0]), 16'h0);

        // control write to a nonexistent port changes nothing
        bus_write(1'b0, 3'd2, 8'hA1);
        check("ign_pen", 16'(PEn), 16'h1);
        check("ign_nobf", 16'(nOBF), 16'h2);
        bus_read(1'b0, 3'd2, rd, den);
        check("ign_ctrl", 16'(rd), 16'h03);

        // mode set clears the latch; basic modes
        bus_write(1'b0, 3'd2, 8'h81);
        check("m01_pout", 16'(Pout[7:0]), 16'h00);
        check("m01_nobf", 16'(nOBF), 16'h3);
        check("m01_intr", 16'(INTR), 16'h0);
        bus_write(1'b0, 3'd2, 8'h90);
        bus_write(1'b0, 3'd1, 8'h99);
        check("m00_pout", 16'(Pout[15:8]), 16'h99);
        check("m00_pen", 16'(PEn), 16'h1);
        Pin[15:8] = 8'hE7;
        bus_read(1'b0, 3'd1, rd, den);
        check("m00_read_pin", 16'(rd), 16'hE7);

        // strobe held low across reset release must not fill the buffer
        bus_write(1'b0, 3'd2, 8'h92);
        bus_write(1'b0, 3'd2, 8'h11);
        nSTB[1] = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_rst_pen", 16'(PEn), 16'h0);
        wait_cycles(2);
        reset = 1'b0;
        bus_write(1'b0, 3'd2, 8'h92);
        bus_write(1'b0, 3'd2, 8'h11);
        wait_cycles(2);
        nSTB[1] = 1'b1;
        wait_cycles(4);
        check("straddle_ibf", 16'(IBF[1]), 16'h0);
        check("straddle_intr", 16'(INTR[1]), 16'h0);
        nSTB[1] = 1'b0; wait_cycles(4);
        nSTB[1] = 1'b1; wait_cycles(4);
        check("post_rst_ibf", 16'(IBF[1]), 16'h1);

        // four 4-bit ports: highest port in basic output
        bus_write(1'b1, 3'd4, 8'hB1);
        bus_write(1'b1, 3'd3, 8'hFF);
        check("p4_pout", Pout4, 16'hF000);
        check("p4_pen", 16'(PEn4), 16'h8);
        bus_read(1'b1, 3'd3, rd, den);
        check("p4_read", 16'(rd), 16'h0F);
        bus_read(1'b1, 3'd5, rd, den);
        check("p4_status", 16'(rd), 16'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
